sprite_config_arbiter: RTL
==========================

// Module: sprite_config_arbiter
// PURPOSE
//   Shares the rectangular-sprite bounds registers between NUM_REQ writers (game logic, input, debug UART).
//   Writers post updates into a shadow bank through round-robin arbitration.
//   The shadow bank is copied atomically into the active bank once per frame, on new_frame_in.
//   The active bank drives the xmin/ymin/xmax/ymax inputs of the minmax-style block sprites, so no tearing mid-frame.
// PARAMETERS
//   NUM_REQ      4   number of requesters; must be >= 2
//   NUM_SPRITES  8   number of sprite slots; sprite id width = $clog2(NUM_SPRITES)
// PORTS
//   clk_in          in   1                pixel clock
//   rst_in          in   1                synchronous, active-high reset
//   new_frame_in    in   1                one-cycle pulse at start of vertical blanking
//   req_valid_in    in   NUM_REQ          per-requester update valid
//   req_ready_out   out  NUM_REQ          one-hot grant; transfer when valid&ready
//   req_id_in       in   NUM_REQ*IDW      sprite slot, requester r at [r*IDW +: IDW]
//   req_box_in      in   NUM_REQ*43       {en[1], xmin[11], ymin[10], xmax[11], ymax[10]} per requester
//   active_box_out  out  NUM_SPRITES*43   active bank, same packing, slot s at [s*43 +: 43]
//   commit_out      out  1                pulses the cycle the active bank changes
//   err_out         out  1                pulses on a rejected update (bad bounds)
//   err_req_out     out  $clog2(NUM_REQ)  requester index of the last rejection
// BEHAVIOUR
//   Reset
//     - Shadow and active banks cleared; all en=0, so the sprites draw nothing.
//     - rr pointer=0; commit_out=0; err_out=0; err_req_out=0.
//   Arbitration (combinational grant)
//     - req_ready_out = one-hot of the first valid requester searching from rr pointer upward, with wrap.
//     - All zeros if no valid, or if new_frame_in=1 (commit stall).
//     - Ready never asserts to a requester whose valid is low.
//   Transfer r at edge k
//     - Shadow slot req_id is written at edge k.
//     - rr pointer <- (r+1) mod NUM_REQ.
//     - Pointer holds when there is no transfer.
//   Validation
//     - xmax<xmin or ymax<ymin: the transfer still completes (ready given), shadow is not written.
//     - err_out=1 on the next cycle; err_req_out=r, held until the next rejection.
//     - en=0 boxes are written without any bounds check.
//   Commit
//     - new_frame_in=1 at edge k: active <- shadow (all slots) at edge k; commit_out=1 the cycle after edge k.
//     - No grant during that cycle, so the copy is atomic.
//     - A requester held off keeps valid high and is granted next cycle; pointer unchanged.
//   Latency
//     - An accepted update is visible on active_box_out from the first commit strictly after its transfer edge.
//     - Minimum is 1 cycle: transfer at k, new_frame_in at k+1.
//   Boundaries
//     - Two writes to the same slot in one frame: the last one wins.
//     - req_id >= NUM_SPRITES: treated as a rejection (err_out).
//     - new_frame_in held high for several cycles: commits every cycle, grants stay stalled.
//     - rst_in wins over new_frame_in and over transfers; reset mid-frame blanks all sprites immediately.
//   Widths
//     - x fields are 11 bits, y fields 10 bits, matching hcount/vcount.
//     - Comparisons are unsigned; there is no arithmetic on coordinates.
// STRUCTURE
//   sprite_cfg_pkg
//     - typedef struct packed sprite_box_t {en, xmin, ymin, xmax, ymax}.
//     - BOX_W=43, X_W=11, Y_W=10.
//   Sub-module rr_arbiter #(N): req vector + pointer in -> one-hot grant + encoded index out; purely combinational.
//   Top holds the shadow/active arrays, pointer register, validation and commit logic.
// TESTING
//   1. Reset, then new_frame_in -> all active en=0, commit_out pulses once.
//   2. r1 writes slot 2 {1,100,50,200,150}, commit two cycles later -> active slot 2 equals it; other slots are 0.
//   3. r0..r3 all valid continuously, pointer=0 -> grants r0,r1,r2,r3,r0 on consecutive cycles.
//   4. r2 valid in the same cycle as new_frame_in -> ready=0 that cycle, granted the next; its data is not in this commit.
//   5. r3 writes xmin=300, xmax=200 -> ready=1; err_out pulses with err_req_out=3; shadow slot unchanged after commit.
//   6. Slot 5 written at frame N, reset asserted before commit -> slot 5 active en=0 and shadow cleared.

Source files
------------

// File: rtl/sprite_cfg_pkg.sv
// Shared types and widths for the sprite bounds configuration path.
// A box is {en, xmin, ymin, xmax, ymax}, msb first, 43 bits wide.
package sprite_cfg_pkg;

    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int BOX_W = 1 + 2 * X_W + 2 * Y_W;

    typedef struct packed {
        logic           en;
        logic [X_W-1:0] xmin;
        logic [Y_W-1:0] ymin;
        logic [X_W-1:0] xmax;
        logic [Y_W-1:0] ymax;
    } sprite_box_t;

    // Disabled boxes are never bounds-checked; enabled ones need max >= min.
    function automatic logic box_bounds_ok(input sprite_box_t b);
        return !b.en || ((b.xmax >= b.xmin) && (b.ymax >= b.ymin));
    endfunction

endpackage

// File: rtl/sprite_config_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above the
// pointer, wrapping, as a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    logic [PW:0]   cand;
    logic [PW-1:0] cand_idx;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = '0;
        cand_idx = '0;
        for (int off = 0; off < N; off++) begin
            cand = {1'b0, ptr_i} + (PW+1)'(off);
            if (cand >= (PW+1)'(N)) begin
                cand = cand - (PW+1)'(N);
            end
            cand_idx = cand[PW-1:0];
            if (!any_o && req_i[cand_idx]) begin
                any_o           = 1'b1;
                idx_o           = cand_idx;
                gnt_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_config_arbiter.sv
// Round-robin writers update a shadow bank of sprite boxes; the whole shadow
// bank is copied to the active bank on each new_frame_in so sprites never tear.
module sprite_config_arbiter
    import sprite_cfg_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int NUM_SPRITES = 8,
    localparam int IDW = $clog2(NUM_SPRITES),
    localparam int RW  = $clog2(NUM_REQ)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         new_frame_in,
    input  logic [NUM_REQ-1:0]           req_valid_in,
    output logic [NUM_REQ-1:0]           req_ready_out,
    input  logic [NUM_REQ*IDW-1:0]       req_id_in,
    input  logic [NUM_REQ*BOX_W-1:0]     req_box_in,
    output logic [NUM_SPRITES*BOX_W-1:0] active_box_out,
    output logic                         commit_out,
    output logic                         err_out,
    output logic [RW-1:0]                err_req_out
);

    logic [IDW-1:0] id_arr  [NUM_REQ];
    sprite_box_t    box_arr [NUM_REQ];
    sprite_box_t    shadow_q[NUM_SPRITES];
    sprite_box_t    active_q[NUM_SPRITES];

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] gnt;
    logic [RW-1:0]      gnt_idx;
    logic               gnt_any;

    logic [IDW-1:0] sel_id;
    sprite_box_t    sel_box;
    logic           id_ok;
    logic           reject;
    logic           accept;

    logic [RW-1:0] ptr_q, ptr_d;
    logic          commit_q, commit_d;
    logic          err_q, err_d;
    logic [RW-1:0] err_req_q, err_req_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign id_arr[gi]  = req_id_in[gi*IDW +: IDW];
            assign box_arr[gi] = sprite_box_t'(req_box_in[gi*BOX_W +: BOX_W]);
        end
    endgenerate

    // Grants are withheld during a commit cycle so the bank copy is atomic.
    assign arb_req = new_frame_in ? '0 : req_valid_in;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i (arb_req),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign req_ready_out = gnt;

    assign sel_id  = id_arr[gnt_idx];
    assign sel_box = box_arr[gnt_idx];
    assign id_ok   = ({1'b0, sel_id} < (IDW+1)'(NUM_SPRITES));
    assign reject  = gnt_any && (!id_ok || !box_bounds_ok(sel_box));
    assign accept  = gnt_any && !reject;

    always_comb begin
        ptr_d     = ptr_q;
        commit_d  = new_frame_in;
        err_d     = reject;
        err_req_d = err_req_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == RW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
        if (reject) begin
            err_req_d = gnt_idx;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ptr_q     <= '0;
            commit_q  <= 1'b0;
            err_q     <= 1'b0;
            err_req_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            commit_q  <= commit_d;
            err_q     <= err_d;
            err_req_q <= err_req_d;
        end
    end

    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_slot
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    shadow_q[gi] <= '0;
                end else if (accept && (sel_id == IDW'(gi))) begin
                    shadow_q[gi] <= sel_box;
                end
            end

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    active_q[gi] <= '0;
                end else if (new_frame_in) begin
                    active_q[gi] <= shadow_q[gi];
                end
            end

            assign active_box_out[gi*BOX_W +: BOX_W] = active_q[gi];
        end
    endgenerate

    assign commit_out  = commit_q;
    assign err_out     = err_q;
    assign err_req_out = err_req_q;

endmodule
